// File: rtl/bp_pkg.sv
// Shared branch-predictor types: counter width default, init value, FSM states.
package bp_pkg;

   localparam int unsigned CTR_W_DEF    = 2;
   localparam int unsigned INIT_VAL_DEF = 1 << (CTR_W_DEF - 1);

   typedef logic [CTR_W_DEF-1:0] ctr_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Saturating step of a default-width counter toward the resolved outcome.
   function automatic ctr_t sat_update(ctr_t ctr, logic taken);
      if (taken) begin
         return (ctr == '1) ? ctr : ctr + ctr_t'(1);
      end
      return (ctr == '0) ? ctr : ctr - ctr_t'(1);
   endfunction

endpackage

// File: rtl/bim_ctr_update.sv
// Combinational saturating increment/decrement of one predictor counter.
module bim_ctr_update #(
   parameter int unsigned CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr_i,
   input  logic             taken_i,
   output logic [CTR_W-1:0] ctr_c_o
);

   always_comb begin
      ctr_c_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != '1) ctr_c_o = ctr_i + CTR_W'(1);
      end else begin
         if (ctr_i != '0) ctr_c_o = ctr_i - CTR_W'(1);
      end
   end

endmodule

// File: rtl/bim_counter_table.sv
// Bimodal counter table: registered read ports, internal saturating RMW update,
// self-initialising sweep after reset and flush.
module bim_counter_table
   import bp_pkg::*;
#(
   parameter int unsigned SET_IDX      = 8,
   parameter int unsigned CTR_W        = CTR_W_DEF,
   parameter int unsigned NUM_RD       = 2,
   parameter int unsigned INIT_VAL     = 1 << (CTR_W - 1),
   parameter int unsigned INIT_PER_CYC = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush_i,
   output logic                      ready_o,
   input  logic [NUM_RD*SET_IDX-1:0] rd_addr_i,
   output logic [NUM_RD*CTR_W-1:0]   rd_data_o,
   input  logic                      upd_valid_i,
   input  logic [SET_IDX-1:0]        upd_addr_i,
   input  logic                      upd_taken_i
);

   localparam int unsigned DEPTH   = 1 << SET_IDX;
   localparam int unsigned GRP_LG  = $clog2(INIT_PER_CYC);
   localparam int unsigned PTR_W   = SET_IDX - GRP_LG;
   localparam int unsigned NUM_GRP = DEPTH / INIT_PER_CYC;
   localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);

   state_e                     state_q, state_d;
   logic [PTR_W-1:0]           init_ptr_q, init_ptr_d;
   logic                       ready_q;
   logic                       u1_valid_q, u1_valid_d;
   logic [SET_IDX-1:0]         u1_addr_q;
   logic                       u1_taken_q;
   logic [NUM_RD*CTR_W-1:0]    rd_data_q, rd_data_d;

   logic [CTR_W-1:0]           mem [DEPTH];
   logic [CTR_W-1:0]           u1_old_c;
   logic [CTR_W-1:0]           u1_new_c;
   logic                       in_init_c;
   logic                       upd_we_c;

   assign in_init_c = (state_q == INIT) || flush_i;
   assign upd_we_c  = u1_valid_q && (state_q == RUN) && !flush_i;
   assign u1_old_c  = mem[u1_addr_q];

   bim_ctr_update #(.CTR_W(CTR_W)) u_upd (
      .ctr_i   (u1_old_c),
      .taken_i (u1_taken_q),
      .ctr_c_o (u1_new_c)
   );

   // Sweep / run sequencing
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      case (state_q)
         INIT: begin
            if (flush_i) begin
               init_ptr_d = '0;
            end else if (init_ptr_q == PTR_W'(NUM_GRP - 1)) begin
               state_d    = RUN;
               init_ptr_d = '0;
            end else begin
               init_ptr_d = init_ptr_q + PTR_W'(1);
            end
         end
         RUN: begin
            if (flush_i) begin
               state_d    = INIT;
               init_ptr_d = '0;
            end
         end
         default: state_d = INIT;
      endcase
   end

   assign u1_valid_d = (state_q == RUN) && !flush_i && upd_valid_i;

   // Read ports; a read matching the in-flight update sees the new value
   always_comb begin
      rd_data_d = rd_data_q;
      for (int p = 0; p < int'(NUM_RD); p++) begin
         if (in_init_c) begin
            rd_data_d[p*CTR_W +: CTR_W] = INIT_CTR;
         end else if (u1_valid_q && (rd_addr_i[p*SET_IDX +: SET_IDX] == u1_addr_q)) begin
            rd_data_d[p*CTR_W +: CTR_W] = u1_new_c;
         end else begin
            rd_data_d[p*CTR_W +: CTR_W] = mem[rd_addr_i[p*SET_IDX +: SET_IDX]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         init_ptr_q <= '0;
         ready_q    <= 1'b0;
         u1_valid_q <= 1'b0;
         u1_addr_q  <= '0;
         u1_taken_q <= 1'b0;
         rd_data_q  <= {NUM_RD{INIT_CTR}};
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
         ready_q    <= (state_d == RUN);
         u1_valid_q <= u1_valid_d;
         u1_addr_q  <= upd_addr_i;
         u1_taken_q <= upd_taken_i;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage has no reset; the sweep owns initialisation
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         for (int i = 0; i < int'(INIT_PER_CYC); i++) begin
            mem[(SET_IDX'(init_ptr_q) << GRP_LG) | SET_IDX'(i)] <= INIT_CTR;
         end
      end else if (upd_we_c) begin
         mem[u1_addr_q] <= u1_new_c;
      end
   end

   assign ready_o   = ready_q;
   assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_bim_counter_table.sv
// Scoreboard bench for bim_counter_table: directed reads/updates, flush and reset cases.
module tb_bim_counter_table;

   logic        clk;
   logic        rst_n;
   logic        flush_i;
   logic        ready_o;
   logic [15:0] rd_addr_i;
   logic [3:0]  rd_data_o;
   logic        upd_valid_i;
   logic [7:0]  upd_addr_i;
   logic        upd_taken_i;

   typedef struct {
      logic [1:0] v;
      string      nm;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   logic [1:0] chk_en;
   logic [1:0] chk_pipe;
   int n_chk = 0;
   int n_err = 0;

   bim_counter_table #(
      .SET_IDX(8), .CTR_W(2), .NUM_RD(2), .INIT_VAL(2), .INIT_PER_CYC(4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .ready_o     (ready_o),
      .rd_addr_i   (rd_addr_i),
      .rd_data_o   (rd_data_o),
      .upd_valid_i (upd_valid_i),
      .upd_addr_i  (upd_addr_i),
      .upd_taken_i (upd_taken_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Advance one cycle and clear per-cycle stimulus
   task automatic step();
      @(posedge clk);
      #1;
      chk_en      = '0;
      flush_i     = 1'b0;
      upd_valid_i = 1'b0;
   endtask

   task automatic rd(input int p, input logic [7:0] a, input logic [1:0] e, input string nm);
      exp_t x;
      x.v  = e;
      x.nm = nm;
      if (p == 0) begin
         rd_addr_i[7:0] = a;
         chk_en[0]      = 1'b1;
         sb0.push_back(x);
      end else begin
         rd_addr_i[15:8] = a;
         chk_en[1]       = 1'b1;
         sb1.push_back(x);
      end
   endtask

   task automatic upd(input logic [7:0] a, input logic t);
      upd_valid_i = 1'b1;
      upd_addr_i  = a;
      upd_taken_i = t;
   endtask

   task automatic count_ready(input string nm);
      repeat (63) step();
      chk({nm, "_ready_early"}, ready_o, 0);
      step();
      chk({nm, "_ready_rise"}, ready_o, 1);
   endtask

   // Read data for a port is presented one edge after the address
   always @(posedge clk) chk_pipe <= chk_en;

   always @(negedge clk) begin
      exp_t x;
      if (chk_pipe[0]) begin
         if (sb0.size() == 0) chk("sb0_underflow", 1, 0);
         else begin
            x = sb0.pop_front();
            chk(x.nm, rd_data_o[1:0], x.v);
         end
      end
      if (chk_pipe[1]) begin
         if (sb1.size() == 0) chk("sb1_underflow", 1, 0);
         else begin
            x = sb1.pop_front();
            chk(x.nm, rd_data_o[3:2], x.v);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      int tk[7];
      int ex[7];
      tk = '{1, 1, 1, 0, 0, 0, 0};
      ex = '{3, 3, 3, 2, 1, 0, 0};
      rst_n = 1'b0; flush_i = 1'b0; rd_addr_i = '0; chk_en = '0;
      upd_valid_i = 1'b0; upd_addr_i = '0; upd_taken_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", ready_o, 0);
      chk("rst_rd0", rd_data_o[1:0], 2);
      chk("rst_rd1", rd_data_o[3:2], 2);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Initial sweep; an update in the last INIT cycle must be ignored
      repeat (63) step();
      chk("init_ready_early", ready_o, 0);
      upd(8'h07, 1'b1);
      rd(1, 8'h07, 2, "init_rd07");
      step();
      chk("init_ready_rise", ready_o, 1);
      rd(0, 8'h07, 2, "ign07_a");
      step();
      rd(1, 8'h07, 2, "ign07_b");
      rd(0, 8'h00, 2, "t1_p0_00");
      step();
      rd(0, 8'hFF, 2, "t1_p0_ff");
      rd(1, 8'h00, 2, "t1_p1_00");
      step();
      rd(1, 8'hFF, 2, "t1_p1_ff");
      step();

      // Saturating update sequence on 0x12
      for (int i = 0; i < 8; i++) begin
         if (i < 7) upd(8'h12, tk[i][0]);
         if (i > 0) rd(0, 8'h12, ex[i-1][1:0], "t2_seq");
         step();
      end
      rd(1, 8'h12, 0, "t2_array");
      step();

      // Pre-update read, bypass read, array read
      upd(8'h40, 1'b1);
      rd(0, 8'h40, 2, "t3_pre");
      step();
      rd(1, 8'h40, 3, "t3_bypass");
      step();
      rd(0, 8'h40, 3, "t3_arr0");
      rd(1, 8'h40, 3, "t3_arr1");
      step();

      // Flush with update pending in the pipeline
      upd(8'h05, 1'b1);
      step();
      flush_i = 1'b1;
      rd(0, 8'h05, 2, "t4_flush_rd");
      step();
      chk("t4_ready_drop", ready_o, 0);
      rd(1, 8'h12, 2, "t4_sweep_rd");
      count_ready("t4");
      rd(0, 8'h05, 2, "t4_rd05");
      rd(1, 8'h12, 2, "t4_rd12");
      step();
      rd(0, 8'h40, 2, "t4_rd40");
      step();

      // Reset mid-sweep at pointer 20
      flush_i = 1'b1;
      step();
      repeat (20) step();
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5a_ready", ready_o, 0);
      chk("t5a_rd0", rd_data_o[1:0], 2);
      chk("t5a_rd1", rd_data_o[3:2], 2);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      count_ready("t5a");

      // Reset with an update in flight and a non-init value on the outputs
      upd(8'h33, 1'b1);
      step();
      upd(8'h33, 1'b1);
      rd(0, 8'h33, 3, "t5b_byp0");
      rd(1, 8'h33, 3, "t5b_byp1");
      step();
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5b_ready", ready_o, 0);
      chk("t5b_rd0", rd_data_o[1:0], 2);
      chk("t5b_rd1", rd_data_o[3:2], 2);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      count_ready("t5b");
      rd(0, 8'h33, 2, "t5b_rd33_0");
      rd(1, 8'h33, 2, "t5b_rd33_1");
      step();
      step();
      step();
      chk("sb_drain", 32'(sb0.size() + sb1.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
